fft_np_framer: RTL and testbench

Input framer that sits directly upstream of `fft_np`. It accepts a stream of complex samples, one per handshake, and assembles each group of N samples into a parallel frame in the packed layout `fft_np` consumes on `data_in`. Double buffering lets one frame fill while the previous frame waits for the consumer. Frame boundaries come from a sample counter and can be resynchronised with a start-of-frame marker.

---
 rtl/fft_pkg.sv | 39 +++
 rtl/fft_np_framer.sv | 134 +++++++++++++
 tb/tb_fft_np_framer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the fft_np datapath: sample layout, frame slot
// addressing and index helpers used by the framer.
package fft_pkg;

    localparam int DEFAULT_SAMPLE_WIDTH = 16;
    localparam int DEFAULT_HALF_WIDTH   = DEFAULT_SAMPLE_WIDTH / 2;

    // Real part sits in the low half, imaginary part in the high half.
    typedef struct packed {
        logic signed [DEFAULT_HALF_WIDTH-1:0] imag;
        logic signed [DEFAULT_HALF_WIDTH-1:0] re;
    } sample_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

    function automatic int unsigned bitrev(input int unsigned idx, input int bits);
        int unsigned result;
        result = 0;
        for (int b = 0; b < bits; b++) begin
            result = (result << 1) | ((idx >> b) & 32'd1);
        end
        return result;
    endfunction

    function automatic int slot_offset(input int slot, input int width);
        return slot * width;
    endfunction

endpackage

// File: rtl/fft_np_framer.sv
// Collects a stream of complex samples into N-sample parallel frames for
// fft_np, with one frame of double buffering and start-of-frame resync.
module fft_np_framer
    import fft_pkg::*;
#(
    parameter int N            = 4,
    parameter int SAMPLE_WIDTH = 16,
    parameter int BIT_REV      = 0
) (
    input  logic                      clk,
    input  logic                      arst_n,
    input  logic [SAMPLE_WIDTH-1:0]   s_data_i,
    input  logic                      s_valid_i,
    input  logic                      s_sof_i,
    output logic                      s_ready_o,
    output logic [N*SAMPLE_WIDTH-1:0] frame_o,
    output logic                      frame_valid_o,
    input  logic                      frame_ready_i,
    output logic [15:0]               frame_count_o,
    output logic                      sync_err_o
);

    localparam int CW = (clog2(N) < 1) ? 1 : clog2(N);

    if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
        $error("fft_np_framer: N must be a power of two and at least 2");
    end
    if ((SAMPLE_WIDTH % 2) != 0) begin : g_bad_width
        $error("fft_np_framer: SAMPLE_WIDTH must be even");
    end

    typedef logic [SAMPLE_WIDTH-1:0] word_t;

    word_t                      buf_q [N];
    word_t                      buf_d [N];
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       fill_full_q, fill_full_d;
    logic [N*SAMPLE_WIDTH-1:0]  frame_q, frame_d;
    logic                       frame_valid_q, frame_valid_d;
    logic [15:0]                frame_count_q, frame_count_d;
    logic                       sync_err_q, sync_err_d;
    logic                       s_ready_q, s_ready_d;

    logic                       in_xfer;
    logic                       out_xfer;
    logic                       resync;
    logic                       complete;
    logic [CW-1:0]              widx;
    logic [CW-1:0]              wslot;
    logic [N*SAMPLE_WIDTH-1:0]  frame_fill;

    always_comb begin
        in_xfer  = s_valid_i && s_ready_q;
        out_xfer = frame_valid_q && frame_ready_i;
        resync   = in_xfer && s_sof_i && (cnt_q != '0);
        // A marker always restarts the frame at index 0, discarding any partial fill.
        widx     = (in_xfer && s_sof_i) ? '0 : cnt_q;
        wslot    = (BIT_REV != 0) ? CW'(bitrev(32'(widx), CW)) : widx;
        complete = in_xfer && (widx == CW'(N - 1));

        for (int i = 0; i < N; i++) begin
            buf_d[i] = buf_q[i];
        end
        if (in_xfer) begin
            buf_d[wslot] = s_data_i;
        end

        frame_fill = '0;
        for (int i = 0; i < N; i++) begin
            frame_fill[slot_offset(i, SAMPLE_WIDTH) +: SAMPLE_WIDTH] = buf_d[i];
        end

        cnt_d = cnt_q;
        if (in_xfer) begin
            cnt_d = widx + CW'(1);
        end

        fill_full_d   = fill_full_q;
        frame_d       = frame_q;
        frame_valid_d = frame_valid_q;
        if (fill_full_q) begin
            if (out_xfer) begin
                frame_d     = frame_fill;
                fill_full_d = 1'b0;
            end
        end else if (complete) begin
            if (!frame_valid_q || out_xfer) begin
                frame_d       = frame_fill;
                frame_valid_d = 1'b1;
            end else begin
                fill_full_d = 1'b1;
            end
        end else if (out_xfer) begin
            frame_valid_d = 1'b0;
        end

        s_ready_d     = !fill_full_d;
        sync_err_d    = resync;
        frame_count_d = frame_count_q + 16'(out_xfer);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < N; i++) begin
                buf_q[i] <= '0;
            end
            cnt_q         <= '0;
            fill_full_q   <= 1'b0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
            frame_count_q <= '0;
            sync_err_q    <= 1'b0;
            s_ready_q     <= 1'b1;
        end else begin
            for (int i = 0; i < N; i++) begin
                buf_q[i] <= buf_d[i];
            end
            cnt_q         <= cnt_d;
            fill_full_q   <= fill_full_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
            frame_count_q <= frame_count_d;
            sync_err_q    <= sync_err_d;
            s_ready_q     <= s_ready_d;
        end
    end

    assign s_ready_o     = s_ready_q;
    assign frame_o       = frame_q;
    assign frame_valid_o = frame_valid_q;
    assign frame_count_o = frame_count_q;
    assign sync_err_o    = sync_err_q;

endmodule

// File: tb/tb_fft_np_framer.sv
// Directed bench for fft_np_framer (N=4, 16-bit samples) in natural and
// bit-reversed order, plus a randomised handshake run against a frame queue.
module tb_fft_np_framer;

    logic        clk;
    logic        arst_n;
    logic [15:0] s_data_i;
    logic        s_valid_i;
    logic        s_sof_i;
    logic        s_ready_o;
    logic [63:0] frame_o;
    logic        frame_valid_o;
    logic        frame_ready_i;
    logic [15:0] frame_count_o;
    logic        sync_err_o;

    logic        rev_s_ready;
    logic [63:0] rev_frame;
    logic        rev_frame_valid;
    logic [15:0] rev_frame_count;
    logic        rev_sync_err;

    int checks = 0;
    int errors = 0;

    fft_np_framer #(.N(4), .SAMPLE_WIDTH(16), .BIT_REV(0)) u_dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .s_data_i      (s_data_i),
        .s_valid_i     (s_valid_i),
        .s_sof_i       (s_sof_i),
        .s_ready_o     (s_ready_o),
        .frame_o       (frame_o),
        .frame_valid_o (frame_valid_o),
        .frame_ready_i (frame_ready_i),
        .frame_count_o (frame_count_o),
        .sync_err_o    (sync_err_o)
    );

    fft_np_framer #(.N(4), .SAMPLE_WIDTH(16), .BIT_REV(1)) u_rev (
        .clk           (clk),
        .arst_n        (arst_n),
        .s_data_i      (s_data_i),
        .s_valid_i     (s_valid_i),
        .s_sof_i       (s_sof_i),
        .s_ready_o     (rev_s_ready),
        .frame_o       (rev_frame),
        .frame_valid_o (rev_frame_valid),
        .frame_ready_i (frame_ready_i),
        .frame_count_o (rev_frame_count),
        .sync_err_o    (rev_sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drives one sample for one clock, then withdraws valid at the next negedge.
    task automatic applyStimulus(input logic [15:0] data, input logic sof);
        s_data_i  = data;
        s_sof_i   = sof;
        s_valid_i = 1'b1;
        @(negedge clk);
        s_valid_i = 1'b0;
        s_sof_i   = 1'b0;
    endtask

    task automatic idleCycle();
        s_valid_i = 1'b0;
        s_sof_i   = 1'b0;
        @(negedge clk);
    endtask

    logic [15:0] sample_q[$];
    logic [63:0] frame_q[$];
    logic [15:0] next_data;
    logic [63:0] exp_frame;
    int          exp_count;

    initial begin
        arst_n        = 1'b0;
        s_data_i      = '0;
        s_valid_i     = 1'b0;
        s_sof_i       = 1'b0;
        frame_ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);

        checkOutput("reset_s_ready", 64'(s_ready_o), 64'd1);
        checkOutput("reset_frame_valid", 64'(frame_valid_o), 64'd0);
        checkOutput("reset_frame", frame_o, 64'd0);
        checkOutput("reset_count", 64'(frame_count_o), 64'd0);
        checkOutput("reset_sync_err", 64'(sync_err_o), 64'd0);
        arst_n = 1'b1;
        @(negedge clk);

        // Basic frame, natural and bit-reversed order.
        applyStimulus(16'h0010, 1'b0);
        applyStimulus(16'h0020, 1'b0);
        applyStimulus(16'h0030, 1'b0);
        checkOutput("basic_valid_early", 64'(frame_valid_o), 64'd0);
        applyStimulus(16'h0040, 1'b0);
        checkOutput("basic_valid", 64'(frame_valid_o), 64'd1);
        checkOutput("basic_frame", frame_o, 64'h0040_0030_0020_0010);
        checkOutput("bitrev_frame", rev_frame, 64'h0040_0020_0030_0010);
        idleCycle();
        checkOutput("basic_valid_one_cycle", 64'(frame_valid_o), 64'd0);
        checkOutput("basic_count", 64'(frame_count_o), 64'd1);
        checkOutput("bitrev_count", 64'(rev_frame_count), 64'd1);

        // Backpressure: two frames stream in while the consumer stalls.
        frame_ready_i = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(16'h0100 + 16'(i), 1'b0);
            if (i == 4) begin
                checkOutput("bp_frame1", frame_o, 64'h0104_0103_0102_0101);
                checkOutput("bp_ready_after4", 64'(s_ready_o), 64'd1);
            end
        end
        checkOutput("bp_ready_low", 64'(s_ready_o), 64'd0);
        checkOutput("bp_frame1_held", frame_o, 64'h0104_0103_0102_0101);
        s_data_i  = 16'h01FF;
        s_valid_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        s_valid_i = 1'b0;
        checkOutput("bp_ready_still_low", 64'(s_ready_o), 64'd0);
        checkOutput("bp_frame1_stable", frame_o, 64'h0104_0103_0102_0101);
        checkOutput("bp_count_stalled", 64'(frame_count_o), 64'd1);
        frame_ready_i = 1'b1;
        idleCycle();
        checkOutput("bp_frame2", frame_o, 64'h0108_0107_0106_0105);
        checkOutput("bp_frame2_valid", 64'(frame_valid_o), 64'd1);
        checkOutput("bp_ready_back", 64'(s_ready_o), 64'd1);
        checkOutput("bp_count_drain", 64'(frame_count_o), 64'd2);
        idleCycle();
        checkOutput("bp_valid_cleared", 64'(frame_valid_o), 64'd0);
        checkOutput("bp_count_final", 64'(frame_count_o), 64'd3);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(16'h0200 + 16'(i), 1'b0);
        end
        checkOutput("bp_clean_frame", frame_o, 64'h0204_0203_0202_0201);
        idleCycle();

        // Resync: marker on index 0 is benign, mid-frame marker discards the partial frame.
        applyStimulus(16'h0301, 1'b1);
        applyStimulus(16'h0302, 1'b0);
        checkOutput("sof_at_zero_no_err", 64'(sync_err_o), 64'd0);
        applyStimulus(16'h0050, 1'b1);
        checkOutput("resync_err_pulse", 64'(sync_err_o), 64'd1);
        applyStimulus(16'h0303, 1'b0);
        checkOutput("resync_err_one_cycle", 64'(sync_err_o), 64'd0);
        checkOutput("resync_no_early_frame", 64'(frame_valid_o), 64'd0);
        applyStimulus(16'h0304, 1'b0);
        applyStimulus(16'h0305, 1'b0);
        checkOutput("resync_frame", frame_o, 64'h0305_0304_0303_0050);
        checkOutput("resync_rev_frame", rev_frame, 64'h0305_0303_0304_0050);
        idleCycle();
        checkOutput("resync_count", 64'(frame_count_o), 64'd5);

        // Reset in the middle of a frame.
        applyStimulus(16'h0401, 1'b0);
        applyStimulus(16'h0402, 1'b0);
        applyStimulus(16'h0403, 1'b0);
        arst_n = 1'b0;
        #1;
        checkOutput("midrst_s_ready", 64'(s_ready_o), 64'd1);
        checkOutput("midrst_frame_valid", 64'(frame_valid_o), 64'd0);
        checkOutput("midrst_frame", frame_o, 64'd0);
        checkOutput("midrst_count", 64'(frame_count_o), 64'd0);
        checkOutput("midrst_sync_err", 64'(sync_err_o), 64'd0);
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        applyStimulus(16'hA501, 1'b0);
        applyStimulus(16'hB502, 1'b0);
        applyStimulus(16'hC503, 1'b0);
        applyStimulus(16'hD504, 1'b0);
        checkOutput("postrst_frame", frame_o, 64'hD504_C503_B502_A501);
        checkOutput("postrst_no_sync_err", 64'(sync_err_o), 64'd0);
        idleCycle();
        checkOutput("postrst_count", 64'(frame_count_o), 64'd1);

        // Random valid/ready toggling checked against an in-order frame queue.
        next_data = 16'h1000;
        exp_count = 1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            s_valid_i     = ($urandom_range(0, 3) != 0);
            frame_ready_i = ($urandom_range(0, 2) != 0);
            s_data_i      = next_data;
            s_sof_i       = 1'b0;
            if (frame_valid_o && frame_ready_i) begin
                if (frame_q.size() == 0) begin
                    checkOutput("rand_unexpected_frame", frame_o, 64'hDEAD_DEAD_DEAD_DEAD);
                end else begin
                    exp_frame = frame_q.pop_front();
                    checkOutput("rand_frame", frame_o, exp_frame);
                end
                exp_count++;
            end
            if (s_valid_i && s_ready_o) begin
                sample_q.push_back(next_data);
                next_data = next_data + 16'd1;
                if (sample_q.size() == 4) begin
                    frame_q.push_back({sample_q[3], sample_q[2], sample_q[1], sample_q[0]});
                    sample_q.delete();
                end
            end
            @(negedge clk);
        end
        s_valid_i     = 1'b0;
        frame_ready_i = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (frame_valid_o) begin
                if (frame_q.size() == 0) begin
                    checkOutput("drain_unexpected_frame", frame_o, 64'hDEAD_DEAD_DEAD_DEAD);
                end else begin
                    exp_frame = frame_q.pop_front();
                    checkOutput("drain_frame", frame_o, exp_frame);
                end
                exp_count++;
            end
            @(negedge clk);
        end
        checkOutput("rand_frames_left", 64'(frame_q.size()), 64'd0);
        checkOutput("rand_count", 64'(frame_count_o), 64'(exp_count));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
